// File: rtl/pnr_sysbus_initiator.sv
// PNR system-bus initiator: queued read/write commands issued as one-cycle strobes, ack/timeout response.
// Optional macro PNR_BUS_TIMEOUT_EN enables the WAIT-state timeout abort.
module pnr_sysbus_initiator #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        busy_o,
    output logic [31:0] sys_addr,
    output logic [31:0] sys_wdata,
    output logic        sys_wen,
    output logic        sys_ren,
    input  logic [31:0] sys_rdata,
    input  logic        sys_err,
    input  logic        sys_ack
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [64:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        ready_q, ready_d;
    logic        empty, full_d, push, pop;
    logic [64:0] head;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        wen_q, wen_d, ren_q, ren_d;
    logic        rsp_valid_q, rsp_valid_d, err_q, err_d, tmo_q, tmo_d;
    logic        tmo_hit;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign push  = cmd_valid_i & ready_q;
    assign pop   = (state_q == IDLE) & ~empty;

    // Ready is registered from the next-state pointers so it reads 0 while in reset.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        ready_d  = ~full_d;
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {cmd_we_i, cmd_addr_i, cmd_wdata_i};
    end

`ifdef PNR_BUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = cnt_q + 16'd1;
    assign tmo_hit = (state_q == WAIT) && (cnt_inc == 16'(TIMEOUT));

    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT) cnt_d = cnt_inc;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wen_d       = 1'b0;
        ren_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        case (state_q)
            IDLE: if (!empty) begin
                addr_d  = head[63:32];
                wdata_d = head[31:0];
                wen_d   = head[64];
                ren_d   = ~head[64];
                state_d = ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (sys_ack) begin
                    rdata_d     = sys_rdata;
                    err_d       = sys_err;
                    tmo_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (tmo_hit) begin
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    tmo_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ready_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ready_q     <= ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready_o   = ready_q;
    assign busy_o        = (state_q != IDLE) | ~empty;
    assign sys_addr      = addr_q;
    assign sys_wdata     = wdata_q;
    assign sys_wen       = wen_q;
    assign sys_ren       = ren_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tmo_q;
endmodule
